s9234_cone_seq_eval: RTL and testbench

//  Sequential, parametrised successor of the s9234 mode/status/data decode cone.

---
 rtl/s9234_cone_seq_eval.sv | 147 ++++++++++++++
 tb/tb_s9234_cone_seq_eval.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/s9234_cone_seq_eval.sv
// Sequential s9234 mode/status/data decode cone: one shared evaluator walks CH channel records.
// Optional scan chain over every flop when SCAN_CHAIN_EN is defined.
module s9234_cone_seq_eval #(
  parameter int CH     = 4,
  parameter int DATA_W = 6,
  parameter int STAT_W = 4
) (
  input  logic                   CK,
  input  logic                   RN,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*4-1:0]        mode,
  input  logic [CH*STAT_W-1:0]   stat,
  input  logic [CH*DATA_W-1:0]   data,
  input  logic                   pol,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH-1:0]          result,
  output logic                   busy,
  output logic [1:0]             dbg_state
`ifdef SCAN_CHAIN_EN
  ,
  input  logic                   SE,
  input  logic                   SI,
  output logic                   SO
`endif
);

  // Handshakes: a transfer happens on a rising CK edge where valid and ready are both 1;
  // valid never drops until taken, and input records are sampled only at the accept edge.

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam int N  = 2 + IW + 1 + 4*CH + STAT_W*CH + DATA_W*CH + CH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // All flops live in one vector ordered as the scan chain, head (SI side) at the MSB.
  logic [N-1:0]          chain_q;
  logic [N-1:0]          chain_d;

  logic [1:0]            state_bits;
  state_t                state;
  state_t                state_d;
  logic [IW-1:0]         ch_idx, ch_idx_d;
  logic                  pol_q, pol_d;
  logic [CH*4-1:0]       mode_q, mode_d;
  logic [CH*STAT_W-1:0]  stat_q, stat_d;
  logic [CH*DATA_W-1:0]  data_q, data_d;
  logic [CH-1:0]         result_q, result_d;
  logic                  out_valid_q, out_valid_d;
  logic                  cur_v;
  int                    idx;

  assign {state_bits, ch_idx, pol_q, mode_q, stat_q, data_q, result_q, out_valid_q} = chain_q;
  assign state   = state_t'(state_bits);
  assign chain_d = {state_d, ch_idx_d, pol_d, mode_d, stat_d, data_d, result_d, out_valid_d};

  function automatic logic verdict(input logic [3:0]        m,
                                   input logic [STAT_W-1:0] s,
                                   input logic [DATA_W-1:0] d,
                                   input logic              p);
    if (m == 4'b0000)
      return 1'b0;
    else if (s[0] && (s[STAT_W-1:1] == '0))
      return ((d == '0) | (d == '1)) ^ p;
    else
      return ^d;
  endfunction

  always_comb begin
    state_d     = state;
    ch_idx_d    = ch_idx;
    pol_d       = pol_q;
    mode_d      = mode_q;
    stat_d      = stat_q;
    data_d      = data_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    idx         = int'(ch_idx);
    cur_v       = verdict(mode_q[idx*4 +: 4], stat_q[idx*STAT_W +: STAT_W],
                          data_q[idx*DATA_W +: DATA_W], pol_q);
    case (state)
      IDLE: begin
        if (in_valid) begin
          mode_d   = mode;
          stat_d   = stat;
          data_d   = data;
          pol_d    = pol;
          result_d = '0;
          ch_idx_d = '0;
          state_d  = EVAL;
        end
      end
      EVAL: begin
        result_d[idx] = cur_v;
        if (idx == CH - 1) begin
          ch_idx_d    = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          ch_idx_d = ch_idx + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      // Unused encoding (reachable only via scan) recovers to IDLE.
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      chain_q <= '0;
    end else begin
`ifdef SCAN_CHAIN_EN
      if (SE)
        chain_q <= {SI, chain_q[N-1:1]};
      else
        chain_q <= chain_d;
`else
      chain_q <= chain_d;
`endif
    end
  end

`ifdef SCAN_CHAIN_EN
  assign SO = chain_q[0];
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign dbg_state = state_bits;

endmodule

// File: tb/tb_s9234_cone_seq_eval.sv
// Randomized scoreboard bench for s9234_cone_seq_eval with a channel-verdict reference model.
module tb_s9234_cone_seq_eval;
  localparam int CH = 4;
  localparam int DW = 6;
  localparam int SW = 4;

  logic             CK = 1'b0;
  logic             RN = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [CH*4-1:0]  mode = '0;
  logic [CH*SW-1:0] stat = '0;
  logic [CH*DW-1:0] data = '0;
  logic             pol = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [CH-1:0]    result;
  logic             busy;
  logic [1:0]       dbg_state;
`ifdef SCAN_CHAIN_EN
  logic             SE = 1'b0;
  logic             SI = 1'b0;
  logic             SO;
`endif

  s9234_cone_seq_eval #(.CH(CH), .DATA_W(DW), .STAT_W(SW)) dut (
    .CK(CK), .RN(RN), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .stat(stat), .data(data), .pol(pol),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .busy(busy), .dbg_state(dbg_state)
`ifdef SCAN_CHAIN_EN
    , .SE(SE), .SI(SI), .SO(SO)
`endif
  );

  // clock / reset
  always #5 CK = ~CK;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            acc_cyc = 0;
  logic [CH-1:0] exp_q[$];
  bit            rand_or = 1'b0;
  logic          or_fixed = 1'b1;
  bit            mon_en = 1'b1;
  logic          prev_ov = 1'b0;

  always @(posedge CK) cyc <= cyc + 1;

  always @(posedge CK) begin
    #1;
    out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_fixed;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // reference model: verdict per channel from the rules, plain arithmetic
  function automatic logic [CH-1:0] model(input logic [CH*4-1:0] m, input logic [CH*SW-1:0] s,
                                          input logic [CH*DW-1:0] d, input logic p);
    logic [CH-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int mv, sv, dv;
      mv = int'(m[4*c +: 4]);
      sv = int'(s[SW*c +: SW]);
      dv = int'(d[DW*c +: DW]);
      if (mv == 0)
        r[c] = 1'b0;
      else if (sv == 1)
        r[c] = ((dv == 0) || (dv == (1 << DW) - 1)) ? ~p : p;
      else
        r[c] = 1'($countones(dv) % 2);
    end
    return r;
  endfunction

  // driver
  task automatic send(input logic [CH*4-1:0] m, input logic [CH*SW-1:0] s,
                      input logic [CH*DW-1:0] d, input logic p, input logic [CH-1:0] e);
    int n;
    n = 0;
    @(negedge CK);
    while (!in_ready && n < 100) begin
      @(negedge CK);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      return;
    end
    mode = m; stat = s; data = d; pol = p; in_valid = 1'b1;
    @(posedge CK);
    #1;
    acc_cyc = cyc;
    exp_q.push_back(e);
    in_valid = 1'b0;
    mode = CH*4'($urandom); stat = CH*SW'($urandom); data = CH*DW'($urandom); pol = ~p;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CK);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  always @(negedge CK) begin
    if (!RN) begin
      prev_ov = 1'b0;
    end else if (mon_en) begin
      if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, CH);
      prev_ov = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("result", result, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [CH*4-1:0]  rm;
    logic [CH*SW-1:0] rs;
    logic [CH*DW-1:0] rd;
    logic             rp;
    int               n;

    #1;
    check("in_ready_in_reset", in_ready, 1);
    check("out_valid_in_reset", out_valid, 0);
    @(negedge CK);
    @(negedge CK);
    RN = 1'b1;
    @(negedge CK);
    check("idle_in_ready", in_ready, 1);
    check("idle_busy", busy, 0);
    check("idle_out_valid", out_valid, 0);
    check("idle_result", result, 0);

    // directed vectors with hand-derived expectations
    send(16'h0000, 16'hFFFF, 24'hABCDEF, 1'b0, 4'b0000);
    drain();
    send(16'h1111, 16'h1111, {6'h3F, 6'h00, 6'h15, 6'h01}, 1'b0, 4'b1100);
    drain();
    send(16'h1111, 16'h1111, {6'h3F, 6'h00, 6'h15, 6'h01}, 1'b1, 4'b0011);
    drain();

    // held output: result stable and new requests ignored
    or_fixed = 1'b0;
    @(posedge CK);
    send(16'h8888, 16'h3333, {6'h07, 6'h03, 6'h01, 6'h00}, 1'b0, 4'b1010);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge CK);
      n++;
    end
    check("hold_reach_done", out_valid, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CK);
      mode = CH*4'($urandom); data = CH*DW'($urandom);
      check("hold_result", result, 4'b1010);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    or_fixed = 1'b1;
    drain();
    @(negedge CK);
    check("after_take_idle", busy, 0);

    // abort mid-EVAL
    send(16'h1111, 16'h1111, {6'h3F, 6'h00, 6'h15, 6'h01}, 1'b0, 4'b1100);
    @(posedge CK);
    @(posedge CK);
    #1;
    check("abort_in_eval", dbg_state, 2'd1);
    RN = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 2'd0);
    exp_q.delete();
    @(negedge CK);
    RN = 1'b1;
    send(16'h8888, 16'h3333, {6'h07, 6'h03, 6'h01, 6'h00}, 1'b0, 4'b1010);
    drain();

    // randomized traffic with random backpressure
    rand_or = 1'b1;
    for (int t = 0; t < 40; t++) begin
      for (int c = 0; c < CH; c++) begin
        rm[4*c +: 4]   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        rs[SW*c +: SW] = ($urandom_range(0, 1) == 0) ? SW'(1) : SW'($urandom);
        case ($urandom_range(0, 2))
          0:       rd[DW*c +: DW] = '0;
          1:       rd[DW*c +: DW] = '1;
          default: rd[DW*c +: DW] = DW'($urandom);
        endcase
      end
      rp = 1'($urandom);
      send(rm, rs, rd, rp, model(rm, rs, rd, rp));
    end
    drain();
    rand_or = 1'b0;
    or_fixed = 1'b1;

`ifdef SCAN_CHAIN_EN
    begin
      int len;
      int seen;
      len = 2 + $clog2(CH) + 1 + 4*CH + SW*CH + DW*CH + CH + 1;
      seen = -1;
      mon_en = 1'b0;
      RN = 1'b0;
      @(negedge CK);
      RN = 1'b1;
      SE = 1'b1;
      SI = 1'b1;
      @(posedge CK);
      #1;
      SI = 1'b0;
      for (int k = 1; k <= len + 4 && seen < 0; k++) begin
        @(negedge CK);
        if (SO) seen = k;
        if (seen < 0) @(posedge CK);
      end
      check("scan_length", seen, len);
      @(posedge CK);
      #1;
      SE = 1'b0;
      @(negedge CK);
      check("scan_state_after", dbg_state, 2'd0);
      check("scan_in_ready_after", in_ready, 1);
      mon_en = 1'b1;
      send(16'h1111, 16'h1111, {6'h3F, 6'h00, 6'h15, 6'h01}, 1'b1, 4'b0011);
      drain();
    end
`endif

    repeat (3) @(negedge CK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "timeout");
  end
endmodule
